// File: rtl/sdram_arbiter.sv
// Arbiter and sequencer between three game read slots, ROM-download byte writes
// and periodic refresh, feeding one command at a time to the SDRAM controller.
//
// state | meaning
// IDLE  | pick the next command: refresh, then write, then round-robin read
// ISSUE | sdram_req high, command fields latched and stable
// WAIT  | waiting for sdram_rdy
// DONE  | one cycle: slot ok pulse or write retire
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        wr_busy,
    output logic        wr_overrun,
    input  logic        slot0_req,
    input  logic [21:0] slot0_addr,
    output logic        slot0_ok,
    input  logic        slot1_req,
    input  logic [21:0] slot1_addr,
    output logic        slot1_ok,
    input  logic        slot2_req,
    input  logic [21:0] slot2_addr,
    output logic        slot2_ok,
    output logic [15:0] data_out,
    output logic        sdram_req,
    output logic        sdram_we,
    output logic        sdram_refresh,
    output logic [21:0] sdram_addr,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_dqm,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_dout
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] ref_cnt;
    logic          ref_pend;
    logic          wr_pend;
    logic [21:0]   wr_addr;
    logic [15:0]   wr_din;
    logic [1:0]    wr_dqm;
    logic [1:0]    rr_ptr;
    logic [1:0]    cmd_idx;
    logic [2:0]    slot_req;
    logic          rd_hit;
    logic [1:0]    rd_idx;
    logic [1:0]    cand;
    logic [21:0]   rd_addr;
    logic          grant_ref, grant_wr, grant_rd;

    assign slot_req = {slot2_req, slot1_req, slot0_req};

    // Walk from farthest to nearest so the slot right after the last grant wins.
    always_comb begin
        rd_hit = 1'b0;
        rd_idx = rr_ptr;
        cand   = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            cand = 2'((int'(rr_ptr) + i) % 3);
            if (slot_req[cand]) begin
                rd_hit = 1'b1;
                rd_idx = cand;
            end
        end
    end

    always_comb begin
        case (rd_idx)
            2'd0:    rd_addr = slot0_addr;
            2'd1:    rd_addr = slot1_addr;
            default: rd_addr = slot2_addr;
        endcase
    end

    always_comb begin
        state_nx  = state;
        grant_ref = 1'b0;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    grant_ref = 1'b1;
                    state_nx  = ISSUE;
                end else if (wr_pend) begin
                    grant_wr = 1'b1;
                    state_nx = ISSUE;
                end else if (!downloading && rd_hit) begin
                    grant_rd = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: if (sdram_ack) state_nx = sdram_refresh ? IDLE : WAIT;
            WAIT:  if (sdram_rdy) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ref_cnt       <= '0;
            ref_pend      <= 1'b0;
            wr_pend       <= 1'b0;
            wr_busy       <= 1'b0;
            wr_overrun    <= 1'b0;
            wr_addr       <= '0;
            wr_din        <= '0;
            wr_dqm        <= '0;
            rr_ptr        <= 2'd2;
            cmd_idx       <= 2'd0;
            data_out      <= '0;
            sdram_we      <= 1'b0;
            sdram_refresh <= 1'b0;
            sdram_addr    <= '0;
            sdram_din     <= '0;
            sdram_dqm     <= '0;
        end else begin
            state <= state_nx;

            // An expiry coinciding with the refresh ack re-arms the request.
            if (state == ISSUE && sdram_ack && sdram_refresh) begin
                ref_pend      <= 1'b0;
                sdram_refresh <= 1'b0;
            end
            if (ref_cnt == REF_LAST) begin
                ref_cnt  <= '0;
                ref_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            if (ioctl_wr && wr_busy) begin
                wr_overrun <= 1'b1;
            end else if (ioctl_wr && downloading) begin
                wr_busy <= 1'b1;
                wr_pend <= 1'b1;
                wr_addr <= {1'b0, ioctl_addr[21:1]};
                wr_din  <= {ioctl_data, ioctl_data};
                wr_dqm  <= ioctl_addr[0] ? 2'b01 : 2'b10;
            end
            if (state == DONE && sdram_we) wr_busy <= 1'b0;

            if (grant_ref) begin
                sdram_refresh <= 1'b1;
                sdram_we      <= 1'b0;
                sdram_dqm     <= 2'b00;
            end else if (grant_wr) begin
                wr_pend       <= 1'b0;
                sdram_refresh <= 1'b0;
                sdram_we      <= 1'b1;
                sdram_addr    <= wr_addr;
                sdram_din     <= wr_din;
                sdram_dqm     <= wr_dqm;
            end else if (grant_rd) begin
                sdram_refresh <= 1'b0;
                sdram_we      <= 1'b0;
                sdram_addr    <= rd_addr;
                sdram_dqm     <= 2'b00;
                cmd_idx       <= rd_idx;
                rr_ptr        <= rd_idx;
            end

            if (state == WAIT && sdram_rdy && !sdram_we) data_out <= sdram_dout;
        end
    end

    assign sdram_req = (state == ISSUE);
    assign slot0_ok  = (state == DONE) && !sdram_we && (cmd_idx == 2'd0);
    assign slot1_ok  = (state == DONE) && !sdram_we && (cmd_idx == 2'd1);
    assign slot2_ok  = (state == DONE) && !sdram_we && (cmd_idx == 2'd2);

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbiter and sequencer between the game's SDRAM users and the single-port SDRAM controller on the MiST target. It merges three game read slots, the ROM-download byte writes (ioctl) and periodic auto-refresh into one command at a time. It presents that command to the controller with a request/acknowledge/ready handshake and returns read data to the winning slot. Only ioctl writes are accepted while `downloading` is high.

## Interface
Parameters:
- `REFRESH_CYCLES`, 384: clk cycles between refresh requests.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `downloading` in 1: ROM download active; blocks all slot reads.
- `ioctl_addr` in 22: byte address of download write.
- `ioctl_data` in 8: download byte.
- `ioctl_wr` in 1: one-cycle write strobe, honoured only when `downloading`=1.
- `wr_busy` out 1: download write pending or executing.
- `wr_overrun` out 1: sticky; `ioctl_wr` arrived while `wr_busy`=1.
- `slotN_req` in 1, N=0..2: level; held until `slotN_ok`.
- `slotN_addr` in 22: word address; stable while `slotN_req`=1.
- `slotN_ok` out 1: one-cycle pulse; `data_out` valid.
- `data_out` out 16: shared read data; holds until the next read.
- `sdram_req` out 1: command valid; held until `sdram_ack`.
- `sdram_we` out 1: write command.
- `sdram_refresh` out 1: refresh command.
- `sdram_addr` out 22: word address.
- `sdram_din` out 16: write data.
- `sdram_dqm` out 2: byte mask; 1 = byte masked; bit0 = low byte.
- `sdram_ack` in 1: command accepted this cycle.
- `sdram_rdy` in 1: read data valid or write complete. Arrives at least 1 cycle after `sdram_ack`.
- `sdram_dout` in 16: read data.

## Operation
- State machine states:
  - IDLE.
  - ISSUE: `sdram_req`=1.
  - WAIT: wait for `sdram_rdy`.
  - DONE: one cycle for `slotN_ok` / write retire.
- Grant priority in IDLE, evaluated every cycle:
  1. Refresh pending.
  2. Write pending.
  3. Read slots, round-robin, only when `downloading`=0.
- Round-robin pointer holds the last granted slot. The search starts at last+1 mod 3 and the pointer updates on grant.
- On grant, latch the command fields: address, we, refresh, din, dqm, and slot index.
- Refresh:
  - The counter increments every cycle and wraps at `REFRESH_CYCLES`-1, setting `ref_pend`.
  - ISSUE→IDLE on `sdram_ack`; no `sdram_rdy` is expected. `ref_pend` clears on that ack.
  - An expiry while `ref_pend`=1 does not accumulate: one refresh only.
- Write capture:
  - `ioctl_wr`=1 with `downloading`=1 loads a one-entry buffer.
  - `sdram_addr`={1'b0, `ioctl_addr`[21:1]}.
  - `sdram_din`={`ioctl_data`, `ioctl_data`}.
  - `sdram_dqm`=2'b01 if `ioctl_addr`[0]=1, else 2'b10.
  - `wr_busy` is high from the cycle after the strobe until the DONE cycle of that write.
  - A strobe while busy is dropped and sets `wr_overrun`.
- Reads: ISSUE→WAIT on ack. WAIT→DONE on `sdram_rdy`, which also registers `data_out`←`sdram_dout`. DONE pulses `slotN_ok` for the latched index.
- Writes: ISSUE→WAIT→DONE as for reads, with no `slotN_ok` and no `data_out` update.
- DONE→IDLE unconditionally. Requests are not sampled in DONE, so a slot that drops `req` on its ok cycle is never re-granted.
- `downloading` changing mid-read does not abort the read; it only affects the next IDLE decision.
- Reset mid-operation:
  - Returns to IDLE and drops any pending write.
  - Clears `ref_pend` and the counter.
  - Sets the pointer to slot 2, so slot 0 is searched first.
  - The controller is expected to be reset together with this block.
- Reset values:
  - All outputs are 0, including `data_out`, `sdram_addr`, `sdram_dqm` and `wr_overrun`.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational input→output paths.
- Minimum read: `slotN_req` sampled in IDLE at cycle 0. `sdram_req`=1 at cycle 1. With ack at cycle 1 and rdy at cycle 2, `slotN_ok` and `data_out` are valid at cycle 3. Next grant decision is at cycle 4.
- `sdram_req` deasserts the cycle after `sdram_ack`. Command fields are stable for the whole ISSUE state.
- Minimum refresh is 2 cycles: IDLE, then ISSUE with ack.
- `sdram_rdy` seen in IDLE, ISSUE or DONE is ignored.

## Test plan
- Reset and refresh: assert `rst` for 2 cycles → all outputs 0. With no requests and `REFRESH_CYCLES`=16, `sdram_refresh`+`sdram_req` appear every 16 cycles and drop after ack.
- Single read: slot1 requests 22'h00ABCD; the controller acks immediately and returns 16'h1234 one cycle later → `sdram_addr`=22'h00ABCD, `slot1_ok` at cycle 3 with `data_out`=16'h1234, exactly one ok pulse.
- Round-robin: all three slots hold `req`, each dropping it on its ok → grant order 0,1,2,0,1,2. No slot is granted twice consecutively while others wait.
- Download: `downloading`=1 with strobes to byte addr 5, then 6 (data 8'h5A, 8'hC3), slots requesting → `sdram_addr`=2 then 3; `sdram_dqm`=01 then 10; `sdram_din`=16'h5A5A then 16'hC3C3; no `slotN_ok` until `downloading`=0.
- Overrun: a second `ioctl_wr` while the controller withholds ack → `wr_overrun`=1 sticky, one write issued, cleared only by `rst`.
- Collision: refresh expires in the same cycle as a pending write and a slot read → order refresh, write, read. Reset asserted during WAIT → IDLE next cycle, no ok, `sdram_req`=0.
